// File: rtl/apb_cmd_master_if.sv
// rtl/apb_cmd_master_if.sv - command, response and APB3 signal bundle for apb_cmd_master
interface apb_cmd_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // command stream
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;

    // response stream
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;

    // APB3 initiator side
    logic              psel_o;
    logic              penable_o;
    logic [ADDR_W-1:0] paddr_o;
    logic              pwrite_o;
    logic [DATA_W-1:0] pwdata_o;
    logic              pready_i;
    logic [DATA_W-1:0] prdata_i;
    logic              pslverr_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
        input  pready_i, prdata_i, pslverr_i
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
        output pready_i, prdata_i, pslverr_i
    );
endinterface

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - single-outstanding APB3 initiator driven by a command/response stream
module apb_cmd_master #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    apb_cmd_master_if.master bus
);
    // Wait counter only ever needs to reach TIMEOUT.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic accept;
    logic timeout_hit;

    assign accept      = (state == IDLE) && bus.cmd_valid_i;
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT));

    // State register; reset forces IDLE so psel/penable drop without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: pready completes an ACCESS even in the cycle the timeout would fire.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (bus.pready_i || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch, wait counter and response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                addr_q  <= bus.cmd_addr_i;
                write_q <= bus.cmd_write_i;
                wdata_q <= bus.cmd_write_i ? bus.cmd_wdata_i : '0;
            end
            if (state == SETUP) begin
                wait_cnt <= '0;
            end
            if (state == ACCESS) begin
                if (bus.pready_i) begin
                    err_q   <= bus.pslverr_i;
                    rdata_q <= (!write_q && !bus.pslverr_i) ? bus.prdata_i : '0;
                end else if (timeout_hit) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.cmd_ready_o = (state == IDLE);
    assign bus.psel_o      = (state == SETUP) || (state == ACCESS);
    assign bus.penable_o   = (state == ACCESS);
    assign bus.rsp_valid_o = (state == RESP);
    assign bus.paddr_o     = addr_q;
    assign bus.pwrite_o    = write_q;
    assign bus.pwdata_o    = wdata_q;
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - self-checking bench for apb_cmd_master
module tb_apb_cmd_master;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    // control view {psel, penable, cmd_ready, rsp_valid}
    localparam logic [3:0] CTL_IDLE   = 4'b0010;
    localparam logic [3:0] CTL_SETUP  = 4'b1000;
    localparam logic [3:0] CTL_ACCESS = 4'b1100;
    localparam logic [3:0] CTL_RESP   = 4'b0001;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_cmd_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ctl_now();
        return 64'({bus.psel_o, bus.penable_o, bus.cmd_ready_o, bus.rsp_valid_o});
    endfunction

    function automatic logic [63:0] bus_now();
        return 64'({bus.pwrite_o, bus.paddr_o, bus.pwdata_o});
    endfunction

    function automatic logic [63:0] rsp_now();
        return 64'({bus.rsp_err_o, bus.rsp_rdata_o});
    endfunction

    // A new command is on offer while the master is busy; it must be ignored.
    task automatic junk_cmd();
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'($urandom_range(0, 1));
        bus.cmd_addr_i  = ADDR_W'($urandom);
        bus.cmd_wdata_i = DATA_W'($urandom);
    endtask

    // Entered and left at posedge+1 with the master in IDLE. The slave raises
    // pready after 'waits' low cycles; 'hold' is how many cycles rsp_ready stays low.
    task automatic run_txn(input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, input int waits,
                           input logic serr, input logic [DATA_W-1:0] rd,
                           input int hold);
        logic              timed_out;
        logic              exp_err;
        logic [DATA_W-1:0] exp_rdata;
        logic [63:0]       exp_bus;
        int                n_access;

        timed_out = (waits > TIMEOUT);
        exp_err   = timed_out ? 1'b1 : serr;
        exp_rdata = (!wr && !exp_err) ? rd : '0;
        exp_bus   = 64'({wr, addr, (wr ? wd : {DATA_W{1'b0}})});
        n_access  = timed_out ? TIMEOUT + 1 : waits + 1;

        // IDLE: offer the command
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = wr;
        bus.cmd_addr_i  = addr;
        bus.cmd_wdata_i = wd;
        bus.rsp_ready_i = 1'b0;
        bus.pready_i    = 1'b0;
        @(negedge clk);
        check("idle_ctl", ctl_now(), 64'(CTL_IDLE));
        @(posedge clk); #1;

        // SETUP
        junk_cmd();
        @(negedge clk);
        check("setup_ctl", ctl_now(), 64'(CTL_SETUP));
        check("setup_bus", bus_now(), exp_bus);
        @(posedge clk); #1;

        // ACCESS
        for (int j = 1; j <= n_access; j++) begin
            junk_cmd();
            if (!timed_out && j == waits + 1) begin
                bus.pready_i  = 1'b1;
                bus.pslverr_i = serr;
                bus.prdata_i  = rd;
            end else begin
                bus.pready_i  = 1'b0;
                bus.pslverr_i = 1'($urandom_range(0, 1));
                bus.prdata_i  = DATA_W'($urandom);
            end
            @(negedge clk);
            check("access_ctl", ctl_now(), 64'(CTL_ACCESS));
            check("access_bus", bus_now(), exp_bus);
            @(posedge clk); #1;
        end

        // RESP
        for (int h = 0; h <= hold; h++) begin
            junk_cmd();
            bus.rsp_ready_i = (h == hold);
            bus.pready_i    = 1'($urandom_range(0, 1));
            bus.pslverr_i   = 1'($urandom_range(0, 1));
            bus.prdata_i    = DATA_W'($urandom);
            @(negedge clk);
            check("resp_ctl", ctl_now(), 64'(CTL_RESP));
            check("resp_data", rsp_now(), 64'({exp_err, exp_rdata}));
            check("resp_bus", bus_now(), exp_bus);
            @(posedge clk); #1;
        end
        bus.cmd_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        bus.pready_i    = 1'b0;
    endtask

    // Abort a read partway through ACCESS with an asynchronous reset.
    task automatic reset_mid_access();
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 10'h155;
        bus.cmd_wdata_i = 32'h0;
        bus.pready_i    = 1'b0;
        @(posedge clk); #1;
        junk_cmd();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_reset_ctl", ctl_now(), 64'(CTL_ACCESS));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_ctl", ctl_now(), 64'(CTL_IDLE));
        check("async_reset_bus", bus_now(), 64'd0);
        check("async_reset_rsp", rsp_now(), 64'd0);
        bus.cmd_valid_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b1;
        bus.cmd_addr_i  = 10'h3FF;
        bus.cmd_wdata_i = 32'hA5A5A5A5;
        bus.rsp_ready_i = 1'b0;
        bus.pready_i    = 1'b0;
        bus.prdata_i    = '0;
        bus.pslverr_i   = 1'b0;

        // reset: a valid command must not be captured
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", ctl_now(), 64'(CTL_IDLE));
        check("reset_bus", bus_now(), 64'd0);
        check("reset_rsp", rsp_now(), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // directed cases
        run_txn(1'b1, 10'h004, 32'hDEADBEEF, 0, 1'b0, 32'h0, 0);
        run_txn(1'b0, 10'h004, 32'h0, 3, 1'b0, 32'h12345678, 0);
        run_txn(1'b0, 10'h004, 32'h0, 0, 1'b1, 32'hFFFFFFFF, 0);
        run_txn(1'b0, 10'h2A0, 32'h0, 1000, 1'b0, 32'hCAFEF00D, 0);
        run_txn(1'b0, 10'h2A0, 32'h0, TIMEOUT, 1'b0, 32'hCAFEF00D, 0);
        run_txn(1'b1, 10'h3FF, 32'h01020304, 2, 1'b0, 32'h0, 5);
        run_txn(1'b0, 10'h001, 32'h0, 1, 1'b0, 32'h76543210, 1);

        reset_mid_access();
        run_txn(1'b0, 10'h155, 32'h0, 2, 1'b0, 32'h89ABCDEF, 0);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            logic              wr;
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] wd;
            logic [DATA_W-1:0] rd;
            logic              serr;
            int                waits;
            int                hold;
            wr    = 1'($urandom_range(0, 1));
            addr  = ADDR_W'($urandom);
            wd    = DATA_W'($urandom);
            rd    = DATA_W'($urandom);
            serr  = ($urandom_range(0, 3) == 0);
            waits = int'($urandom_range(0, TIMEOUT + 3));
            hold  = int'($urandom_range(0, 3));
            run_txn(wr, addr, wd, waits, serr, rd, hold);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
APB initiator that turns a valid/ready command stream (read/write, address, write data) into single APB3 transfers. It returns one response per command on a valid/ready response channel, carrying read data and an error flag. Wait states are bounded by a timeout. It drives the APB slave/memory responder in the read/write subsystem and replaces the fixed-address command-code master.

Parameters:
ADDR_W, 10, width of cmd_addr_i and paddr_o
DATA_W, 32, width of write/read data
TIMEOUT, 15, max ACCESS cycles with pready_i low before abort; ACCESS lasts at most TIMEOUT+1 cycles
CNT_W, $clog2(TIMEOUT+1) (min 1), wait counter width (derived, not overridden)

Ports:
clk  in  1  clock, all flops rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready
cmd_write_i  in  1  1 = write, 0 = read
cmd_addr_i  in  ADDR_W  transfer address
cmd_wdata_i  in  DATA_W  write data (ignored for reads)
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors
rsp_err_o  out  1  pslverr_i sampled at completion, or timeout
psel_o  out  1  APB select
penable_o  out  1  APB enable
paddr_o  out  ADDR_W  APB address
pwrite_o  out  1  APB direction
pwdata_o  out  DATA_W  APB write data
pready_i  in  1  APB ready
prdata_i  in  DATA_W  APB read data
pslverr_i  in  1  APB slave error

Behaviour:
- States: IDLE, SETUP, ACCESS, RESP. Reset → IDLE.
- Reset values: psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o = 0; paddr_o, pwdata_o, rsp_rdata_o = 0; wait counter = 0. cmd_ready_o = 1 (decoded from IDLE), but no command is captured while reset is high.
- IDLE: cmd_ready_o=1. On cmd_valid_i: latch write/addr/wdata → SETUP. Latched pwdata = 0 for reads.
- SETUP (1 cycle): psel_o=1, penable_o=0. Clear wait counter → ACCESS.
- ACCESS: psel_o=1, penable_o=1.
  - pready_i=1: complete → RESP. Capture rsp_err_o=pslverr_i. rsp_rdata_o=prdata_i if read and pslverr_i=0, else 0.
  - pready_i=0 and cnt<TIMEOUT: cnt++ and stay.
  - pready_i=0 and cnt==TIMEOUT: abort → RESP with rsp_err_o=1, rsp_rdata_o=0.
  - pready_i=1 always wins over timeout in the same cycle.
- RESP: psel_o=penable_o=0, rsp_valid_o=1. rsp_rdata_o and rsp_err_o are held stable until rsp_ready_i=1 → IDLE.
- cmd_ready_o=0 in SETUP, ACCESS and RESP: one outstanding transfer only.
- paddr_o, pwrite_o and pwdata_o come from the latched registers. They are stable from SETUP through the end of ACCESS and hold their values in RESP/IDLE until the next accept.
- Latency, zero-wait slave: accept edge T → SETUP at T+1 → ACCESS at T+2 → rsp_valid_o at T+3. Each added wait cycle adds 1. Minimum issue interval is 4 cycles with rsp_ready_i tied 1.
- Reset mid-transfer: psel_o and penable_o drop asynchronously, state → IDLE, and the pending response is discarded.
- Counter never wraps; it saturates at TIMEOUT by construction.

Test Plan:
- Reset then write addr 0x004, data 0xDEADBEEF, pready_i=1 at first ACCESS → psel high T+1..T+2, penable T+2, pwrite=1, paddr=0x004; rsp_valid T+3, err=0, rdata=0.
- Read addr 0x004, slave returns prdata 0x12345678 after 3 wait cycles → ACCESS lasts 4 cycles; rsp_rdata=0x12345678, err=0; cmd_ready_o low throughout.
- Read with pready_i=1 and pslverr_i=1 → rsp_err=1, rsp_rdata=0 despite prdata_i=0xFFFFFFFF.
- pready_i held 0, TIMEOUT=15 → ACCESS exactly 16 cycles, then rsp_valid with err=1, rdata=0; psel_o=0 in RESP. Repeat with pready_i rising in the 16th cycle → normal completion, err=0.
- rsp_ready_i low for 5 cycles with cmd_valid_i held high → rsp fields stable, cmd_ready_o=0, no new psel. Accept occurs the cycle after the response handshake.
- Assert reset during ACCESS → psel_o/penable_o/rsp_valid_o 0 immediately. After release, a new read completes normally with the correct data.
